inverse_result_serializer: RTL and testbench

Downstream stage of the 7x7 matrix inverse block. It captures the full set of inverse result words in one cycle when a load strobe arrives. It then streams the words out one per handshake, in row-major order, on a valid/ready interface tagged with row and column indices. This frees the inverse core for the next matrix and reduces the wide parallel result bus to a single-word stream for the host or memory writer.

---
 rtl/matinv_pkg.sv | 21 ++
 rtl/rc_index_counter.sv | 37 +++
 rtl/inverse_result_serializer.sv | 105 ++++++++++
 tb/tb_inverse_result_serializer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/matinv_pkg.sv
// Shared constants and helpers for the 7x7 matrix inverse datapath.
package matinv_pkg;

  localparam int unsigned N  = 7;
  localparam int unsigned W  = 32;
  localparam int unsigned NE = N * N;
  localparam int unsigned IW = $clog2(NE);
  localparam int unsigned RW = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam int unsigned FW = NE * W;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Element k (= row*N + col) of a flattened result bus.
  function automatic logic [W-1:0] flat_elem(input logic [FW-1:0] flat, input int unsigned k);
    return flat[k*W +: W];
  endfunction

endpackage

// File: rtl/rc_index_counter.sv
// Linear index with row/column tracking over an N x N matrix in row-major order.
module rc_index_counter
  import matinv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [IW-1:0] idx,
  output logic [RW-1:0] row,
  output logic [RW-1:0] col,
  output logic          at_end_c
);

  // Clear wins over enable; column wraps into the next row.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
      row <= '0;
      col <= '0;
    end else if (en) begin
      idx <= IW'(idx + IW'(1));
      if (col == RW'(N - 1)) begin
        col <= '0;
        row <= RW'(row + RW'(1));
      end else begin
        col <= RW'(col + RW'(1));
      end
    end
  end

  // Current index is the final element.
  always_comb begin
    at_end_c = (idx == IW'(NE - 1));
  end

endmodule

// File: rtl/inverse_result_serializer.sv
// Captures a full inverse result and streams it word by word in row-major order.
module inverse_result_serializer
  import matinv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [FW-1:0] in_flat,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [RW-1:0] out_row,
  output logic [RW-1:0] out_col,
  output logic          out_last,
  output logic          done,
  output logic          overrun
);

  state_t        state;
  logic [W-1:0]  buffer [NE];
  logic [IW-1:0] idx;
  logic [IW-1:0] nxt_idx;
  logic          at_end;
  logic          xfer;
  logic          last_xfer;
  logic          accept_load;
  logic          cnt_en;

  // Handshake and load acceptance decode.
  always_comb begin
    xfer        = out_valid && out_ready;
    last_xfer   = xfer && at_end;
    accept_load = load && ((state == IDLE) || last_xfer);
    cnt_en      = xfer && !at_end;
    nxt_idx     = IW'(idx + IW'(1));
  end

  rc_index_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept_load),
    .en       (cnt_en),
    .idx      (idx),
    .row      (out_row),
    .col      (out_col),
    .at_end_c (at_end)
  );

  // Result buffer; contents are don't-care until a load lands.
  always_ff @(posedge clk) begin
    if (accept_load) begin
      for (int unsigned k = 0; k < NE; k++) begin
        buffer[k] <= flat_elem(in_flat, k);
      end
    end
  end

  // Stream control with registered outputs; element 0 bypasses the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done <= last_xfer;
      if (load && !accept_load) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (load) begin
            state     <= STREAM;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= flat_elem(in_flat, 0);
            out_last  <= 1'b0;
          end
        end
        STREAM: begin
          if (last_xfer) begin
            if (load) begin
              out_data <= flat_elem(in_flat, 0);
              out_last <= 1'b0;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end else if (xfer) begin
            out_data <= buffer[nxt_idx];
            out_last <= (idx == IW'(NE - 2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_result_serializer.sv
// Directed scoreboard bench for inverse_result_serializer.
module tb_inverse_result_serializer;
  import matinv_pkg::*;

  typedef struct {
    logic [W-1:0]  d;
    logic [RW-1:0] r;
    logic [RW-1:0] c;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [FW-1:0] in_flat;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [RW-1:0] out_row;
  logic [RW-1:0] out_col;
  logic          out_last;
  logic          done;
  logic          overrun;

  inverse_result_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .in_flat   (in_flat),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  exp_t          sb[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            n_xfer   = 0;
  logic          m_busy   = 1'b0;
  logic          m_done   = 1'b0;
  logic          m_ovr    = 1'b0;
  logic          stall_prev = 1'b0;
  logic [W-1:0]  p_data;
  logic [RW-1:0] p_row;
  logic [RW-1:0] p_col;
  logic          p_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs, drive inputs, advance the reference model.
  task automatic cyc(input logic r_rst, input logic rdy, input logic ld, input logic [31:0] base);
    logic xfer;
    logic last;
    logic stall;
    exp_t e;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (stall_prev) begin
      chk("hold_data", out_data, p_data);
      chk("hold_row", 32'(out_row), 32'(p_row));
      chk("hold_col", 32'(out_col), 32'(p_col));
      chk("hold_last", 32'(out_last), 32'(p_last));
    end
    rst = r_rst;
    out_ready = rdy;
    load = ld;
    if (ld) begin
      for (int k = 0; k < int'(NE); k++) in_flat[k*W +: W] = base + 32'(k);
    end
    p_data = out_data;
    p_row  = out_row;
    p_col  = out_col;
    p_last = out_last;
    if (r_rst) begin
      sb.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_ovr  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      xfer  = m_busy && rdy;
      stall = m_busy && !rdy;
      last  = 1'b0;
      if (xfer) begin
        e = sb.pop_front();
        chk("data", out_data, e.d);
        chk("row", 32'(out_row), 32'(e.r));
        chk("col", 32'(out_col), 32'(e.c));
        chk("last", 32'(out_last), 32'(e.l));
        last = e.l;
        n_xfer++;
      end
      m_done = last;
      if (ld) begin
        if (!m_busy || last) begin
          for (int k = 0; k < int'(NE); k++) begin
            e.d = base + 32'(k);
            e.r = RW'(k / int'(N));
            e.c = RW'(k % int'(N));
            e.l = (k == int'(NE) - 1);
            sb.push_back(e);
          end
          m_busy = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (last) begin
        m_busy = 1'b0;
      end
      stall_prev = stall;
    end
  endtask

  // Drain the current stream with a ready pattern; bounded.
  task automatic drain(input int mode);
    int i;
    i = 0;
    while (m_busy && i < 400) begin
      cyc(1'b0, (mode == 0) ? 1'b1 : (i % 3 == 0), 1'b0, 32'h0);
      i++;
    end
    chk("drain_timeout", 32'(m_busy), 32'h0);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_row", 32'(out_row), 32'h0);
    chk("rst_col", 32'(out_col), 32'h0);
    chk("rst_last", 32'(out_last), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    out_ready = 1'b0;
    in_flat = '0;

    // Reset then idle
    do_reset(2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // Basic stream, ready held high
    n_xfer = 0;
    cyc(1'b0, 1'b1, 1'b1, 32'h1000_0000);
    drain(0);
    chk("basic_count", 32'(n_xfer), 32'(NE));
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // Backpressure
    n_xfer = 0;
    cyc(1'b0, 1'b1, 1'b1, 32'h1000_0000);
    drain(1);
    chk("bp_count", 32'(n_xfer), 32'(NE));
    cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // Overrun: second load at element 10 is ignored
    n_xfer = 0;
    cyc(1'b0, 1'b1, 1'b1, 32'h2000_0000);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h3000_0000);
    drain(0);
    chk("ovr_count", 32'(n_xfer), 32'(NE));
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("ovr_sticky", 32'(overrun), 32'h1);

    // Back-to-back: B loads with A's last transfer
    do_reset(1);
    n_xfer = 0;
    cyc(1'b0, 1'b1, 1'b1, 32'h4000_0000);
    for (int i = 0; i < int'(NE) - 1; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h5000_0000);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("b2b_valid", 32'(out_valid), 32'h1);
    chk("b2b_first", out_data, 32'h5000_0000);
    drain(0);
    chk("b2b_count", 32'(n_xfer), 32'(2 * NE));
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("b2b_ovr", 32'(overrun), 32'h0);

    // Reset mid-stream, then a clean stream
    cyc(1'b0, 1'b1, 1'b1, 32'h6000_0000);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    n_xfer = 0;
    cyc(1'b0, 1'b1, 1'b1, 32'h7000_0000);
    drain(1);
    chk("post_rst_count", 32'(n_xfer), 32'(NE));
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
